// File: rtl/lcd_char_writer_if.sv
// rtl/lcd_char_writer_if.sv - entry stream, controller handshake and cursor status bundle
interface lcd_char_writer_if;
  logic       in_valid;
  logic       in_clr;
  logic [7:0] in_char;
  logic       in_ready;
  logic       busy;
  logic       lcd_enable;
  logic [9:0] lcd_bus;
  logic [5:0] cur_col;
  logic       cur_row;
  logic       idle;

  modport master (
    output in_valid, in_clr, in_char, busy,
    input  in_ready, lcd_enable, lcd_bus, cur_col, cur_row, idle
  );

  modport slave (
    input  in_valid, in_clr, in_char, busy,
    output in_ready, lcd_enable, lcd_bus, cur_col, cur_row, idle
  );
endinterface

// File: rtl/lcd_char_writer.sv
// rtl/lcd_char_writer.sv - buffered character feeder issuing one LCD transfer per controller busy cycle
module lcd_char_writer #(
  parameter int COLS       = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int CLR_WAIT   = 400
) (
  input  logic               clk,
  input  logic               rst_n,
  lcd_char_writer_if.slave   bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLR_WAIT + 1);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT_HI, S_WAIT_LO, S_CLR_HOLD} state_t;

  state_t        state_q, state_d;
  logic [8:0]    fifo_q [FIFO_DEPTH];
  logic [AW:0]   wr_ptr_q, rd_ptr_q;
  logic [5:0]    col_q, col_d;
  logic          row_q, row_d;
  logic          dirty_q, dirty_d;
  logic          clr_q, clr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          en_q, en_d;
  logic [9:0]    bus_q, bus_d;
  logic          empty, full, push, pop;
  logic [8:0]    head;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign push  = bus.in_valid && !full;
  assign head  = fifo_q[rd_ptr_q[AW-1:0]];

  assign bus.in_ready   = !full;
  assign bus.lcd_enable = en_q;
  assign bus.lcd_bus    = bus_q;
  assign bus.cur_col    = col_q;
  assign bus.cur_row    = row_q;
  assign bus.idle       = empty && (state_q == S_IDLE);

  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q[AW-1:0]] <= {bus.in_clr, bus.in_char};
  end

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    dirty_d = dirty_q;
    clr_d   = clr_q;
    cnt_d   = cnt_q;
    en_d    = 1'b0;
    bus_d   = bus_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!empty && !bus.busy) begin
          if (head[8]) begin
            bus_d   = 10'h001;
            en_d    = 1'b1;
            pop     = 1'b1;
            col_d   = 6'd0;
            row_d   = 1'b0;
            dirty_d = 1'b1;
            clr_d   = 1'b1;
            state_d = S_ISSUE;
          end else if (head[7:0] == 8'h0A) begin
            // Newline only moves the cursor; the address command goes out with the next char.
            pop     = 1'b1;
            col_d   = 6'd0;
            row_d   = !row_q;
            dirty_d = 1'b1;
          end else if (dirty_q) begin
            bus_d   = {3'b001, row_q ? 7'h40 : 7'h00};
            en_d    = 1'b1;
            dirty_d = 1'b0;
            state_d = S_ISSUE;
          end else begin
            bus_d   = {2'b10, head[7:0]};
            en_d    = 1'b1;
            pop     = 1'b1;
            state_d = S_ISSUE;
            if (col_q == 6'(COLS - 1)) begin
              col_d   = 6'd0;
              row_d   = !row_q;
              dirty_d = 1'b1;
            end else begin
              col_d = col_q + 6'd1;
            end
          end
        end
      end
      S_ISSUE:   state_d = S_WAIT_HI;
      S_WAIT_HI: if (bus.busy) state_d = S_WAIT_LO;
      S_WAIT_LO: begin
        if (!bus.busy) begin
          bus_d = 10'd0;
          if (clr_q) begin
            cnt_d   = '0;
            state_d = S_CLR_HOLD;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_CLR_HOLD: begin
        if (cnt_q == CW'(CLR_WAIT - 1)) begin
          clr_d   = 1'b0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      col_q    <= 6'd0;
      row_q    <= 1'b0;
      dirty_q  <= 1'b1;
      clr_q    <= 1'b0;
      cnt_q    <= '0;
      en_q     <= 1'b0;
      bus_q    <= 10'd0;
    end else begin
      state_q  <= state_d;
      col_q    <= col_d;
      row_q    <= row_d;
      dirty_q  <= dirty_d;
      clr_q    <= clr_d;
      cnt_q    <= cnt_d;
      en_q     <= en_d;
      bus_q    <= bus_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end
endmodule

// File: tb/tb_lcd_char_writer.sv
// tb/tb_lcd_char_writer.sv - randomized bench for lcd_char_writer against a cursor/transfer reference model
module tb_lcd_char_writer;
  localparam int COLS       = 16;
  localparam int FIFO_DEPTH = 4;
  localparam int CLR_WAIT   = 400;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  lcd_char_writer_if bus ();

  lcd_char_writer #(.COLS(COLS), .FIFO_DEPTH(FIFO_DEPTH), .CLR_WAIT(CLR_WAIT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic busy_force, busy_ctl;
  assign bus.busy = busy_force | busy_ctl;

  int         checks = 0;
  int         errors = 0;
  logic [9:0] obs_q[$];
  logic [9:0] exp_q[$];
  int         m_col;
  bit         m_row, m_dirty;
  bit         ctl_en = 1'b1;
  int         fixed_len = 0;
  bit         prev_en = 1'b0;

  // Reference: each entry maps straight to the transfers it must cause.
  task automatic model_push(input bit clr, input logic [7:0] ch);
    if (clr) begin
      exp_q.push_back(10'h001);
      m_col = 0; m_row = 1'b0; m_dirty = 1'b1;
    end else if (ch == 8'h0A) begin
      m_col = 0; m_row = !m_row; m_dirty = 1'b1;
    end else begin
      if (m_dirty) begin
        exp_q.push_back(m_row ? 10'h0C0 : 10'h080);
        m_dirty = 1'b0;
      end
      exp_q.push_back({2'b10, ch});
      m_col++;
      if (m_col == COLS) begin
        m_col = 0; m_row = !m_row; m_dirty = 1'b1;
      end
    end
  endtask

  initial begin
    busy_ctl = 1'b0;
    forever begin
      @(negedge clk);
      if (ctl_en && rst_n && bus.lcd_enable === 1'b1) begin
        int len;
        obs_q.push_back(bus.lcd_bus);
        len = (fixed_len > 0) ? fixed_len : int'($urandom_range(1, 4));
        @(posedge clk);
        #1 busy_ctl = 1'b1;
        repeat (len) @(posedge clk);
        #1 busy_ctl = 1'b0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && bus.lcd_enable === 1'b1) begin
        checks++;
        if (bus.busy !== 1'b0 || prev_en) begin
          errors++;
          $display("FAIL enable_protocol: busy=%b prev_enable=%b required busy=0 prev_enable=0", bus.busy, prev_en);
        end
      end
      prev_en = (bus.lcd_enable === 1'b1);
    end
  end

  task automatic apply_reset();
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.in_clr = 1'b0; bus.in_char = 8'h00;
    busy_force = 1'b0; ctl_en = 1'b1; fixed_len = 0;
    repeat (3) @(posedge clk);
    obs_q.delete(); exp_q.delete();
    m_col = 0; m_row = 1'b0; m_dirty = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic push_entry(input bit clr, input logic [7:0] ch);
    int n = 0;
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_clr = clr; bus.in_char = ch;
    while (bus.in_ready !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) begin
      checks++; errors++;
      $display("FAIL push_timeout: in_ready=%b required 1 within 2000 cycles", bus.in_ready);
    end else begin
      @(posedge clk);
      model_push(clr, ch);
    end
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(bus.idle === 1'b1 && busy_ctl == 1'b0 && bus.busy === 1'b0) && n < 20000);
    checks++;
    if (n >= 20000) begin
      errors++;
      $display("FAIL %s_drain: idle=%b required 1 within 20000 cycles", name, bus.idle);
    end
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL %s_count: transfers=%0d required %0d", name, obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL %s_bus[%0d]: lcd_bus=%h required %h", name, i, obs_q[i], exp_q[i]);
      end
    end
    checks++;
    if (bus.cur_col !== 6'(m_col) || bus.cur_row !== m_row) begin
      errors++;
      $display("FAIL %s_cursor: col=%0d row=%b required col=%0d row=%b", name, bus.cur_col, bus.cur_row, m_col, m_row);
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic check_reset_outputs(input string name);
    checks++;
    if (bus.lcd_enable !== 1'b0 || bus.lcd_bus !== 10'd0 || bus.cur_col !== 6'd0 ||
        bus.cur_row !== 1'b0 || bus.in_ready !== 1'b1 || bus.idle !== 1'b1) begin
      errors++;
      $display("FAIL %s: en=%b bus=%h col=%0d row=%b ready=%b idle=%b required 0 000 0 0 1 1",
               name, bus.lcd_enable, bus.lcd_bus, bus.cur_col, bus.cur_row, bus.in_ready, bus.idle);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    @(negedge clk);
    check_reset_outputs("reset_state");
  endtask

  task automatic test_single_char();
    apply_reset();
    push_entry(1'b0, 8'h41);
    wait_drain("single_char");
  endtask

  task automatic test_line_wrap();
    apply_reset();
    for (int i = 0; i < 2 * COLS + 17; i++) push_entry(1'b0, 8'(8'h30 + (i % 40)));
    wait_drain("line_wrap");
  endtask

  task automatic test_newline();
    apply_reset();
    push_entry(1'b0, 8'h48);
    push_entry(1'b0, 8'h0A);
    push_entry(1'b0, 8'h49);
    wait_drain("newline");
  endtask

  task automatic test_clear();
    int n, k;
    apply_reset();
    push_entry(1'b0, 8'h51);
    wait_drain("clear_pre");
    fixed_len = 51;
    push_entry(1'b1, 8'h00);
    n = 0;
    while (busy_ctl == 1'b0 && n < 200) begin @(negedge clk); n++; end
    n = 0;
    while (busy_ctl == 1'b1 && n < 200) begin @(negedge clk); n++; end
    while (busy_ctl == 1'b1 && n < 400) begin #1; n++; end
    k = 0;
    do begin
      @(posedge clk);
      #2;
      if (bus.idle !== 1'b1) k++;
    end while (bus.idle !== 1'b1 && k < 2000);
    checks++;
    if (k != CLR_WAIT) begin
      errors++;
      $display("FAIL clear_hold: idle-low cycles=%0d required %0d", k, CLR_WAIT);
    end
    fixed_len = 0;
    push_entry(1'b0, 8'h41);
    wait_drain("clear");
  endtask

  task automatic test_backpressure();
    apply_reset();
    busy_force = 1'b1;
    for (int i = 0; i < FIFO_DEPTH; i++) push_entry(1'b0, 8'(8'h61 + i));
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_clr = 1'b0; bus.in_char = 8'h7A;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (bus.in_ready !== 1'b0 || bus.lcd_enable !== 1'b0) begin
        errors++;
        $display("FAIL full_ready: in_ready=%b en=%b required 0 0", bus.in_ready, bus.lcd_enable);
      end
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    busy_force = 1'b0;
    wait_drain("backpressure");
  endtask

  task automatic test_random();
    apply_reset();
    for (int i = 0; i < 80; i++) begin
      int r = int'($urandom_range(0, 15));
      if (r == 0)      push_entry(1'b1, 8'($urandom));
      else if (r < 3)  push_entry(1'b0, 8'h0A);
      else             push_entry(1'b0, 8'($urandom_range(8'h20, 8'h7E)));
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end
    wait_drain("random");
  endtask

  task automatic test_async_reset();
    int n = 0;
    apply_reset();
    ctl_en = 1'b0;
    push_entry(1'b0, 8'h5A);
    while (bus.lcd_enable !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    @(posedge clk);
    #2;
    checks++;
    if (bus.lcd_bus !== 10'h080 || bus.lcd_enable !== 1'b0) begin
      errors++;
      $display("FAIL wait_hi_bus: lcd_bus=%h en=%b required 080 0", bus.lcd_bus, bus.lcd_enable);
    end
    push_entry(1'b0, 8'h42);
    push_entry(1'b0, 8'h43);
    #3 rst_n = 1'b0;
    #1 check_reset_outputs("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    ctl_en = 1'b1;
    obs_q.delete(); exp_q.delete();
    m_col = 0; m_row = 1'b0; m_dirty = 1'b1;
    push_entry(1'b0, 8'h42);
    wait_drain("after_reset");
  endtask

  initial begin
    busy_force = 1'b0;
    bus.in_valid = 1'b0; bus.in_clr = 1'b0; bus.in_char = 8'h00;
    rst_n = 1'b0;
    test_reset();
    test_single_char();
    test_line_wrap();
    test_newline();
    test_clear();
    test_backpressure();
    test_random();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
